buzzer_driver: RTL and testbench

//   Consumes the level alarm request raised by the intrusion-detect FSM.

---
 rtl/buzzer_driver_if.sv | 19 +
 rtl/buzzer_driver.sv | 119 +++++++++++
 tb/tb_buzzer_driver.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/buzzer_driver_if.sv
// rtl/buzzer_driver_if.sv - alarm request/ack inputs and buzzer status outputs
interface buzzer_driver_if;
  logic       trigger;
  logic       ack;
  logic       buzzer_out;
  logic       active;
  logic       done;
  logic [7:0] beep_count;

  modport master (
    output trigger, ack,
    input  buzzer_out, active, done, beep_count
  );

  modport slave (
    input  trigger, ack,
    output buzzer_out, active, done, beep_count
  );
endinterface

// File: rtl/buzzer_driver.sv
// rtl/buzzer_driver.sv - gated square-wave buzzer with ON/OFF beep cadence
// Runs a burst of beeps per alarm request, silenced early by operator ack.
module buzzer_driver #(
  parameter int HALF_PERIOD = 12500,
  parameter int ON_CYCLES   = 10000000,
  parameter int OFF_CYCLES  = 10000000,
  parameter int BURST_COUNT = 5
) (
  input  logic            clk,
  input  logic            reset,
  buzzer_driver_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2, HOLD = 2'd3} state_t;

  localparam int PH_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW     = $clog2(HALF_PERIOD + 1);
  localparam int PW     = $clog2(PH_MAX + 1);

  localparam logic [TW-1:0] TONE_LAST = TW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] ON_LAST   = PW'(ON_CYCLES - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_CYCLES - 1);
  localparam logic [7:0]    BURST     = 8'(BURST_COUNT);

  state_t        state, state_n;
  logic [TW-1:0] tone_cnt, tone_n;
  logic [PW-1:0] phase_cnt, phase_n;
  logic          buzz, buzz_n;
  logic [7:0]    beep_cnt, beep_n, beep_inc;
  logic          active_r, done_r;

  assign beep_inc = (beep_cnt == 8'hFF) ? beep_cnt : beep_cnt + 8'd1;

  always_comb begin
    state_n = state;
    tone_n  = tone_cnt;
    phase_n = phase_cnt;
    buzz_n  = buzz;
    beep_n  = beep_cnt;
    case (state)
      IDLE: begin
        if (bus.trigger) begin
          state_n = bus.ack ? HOLD : ON;
          tone_n  = '0;
          phase_n = '0;
          buzz_n  = 1'b0;
        end
      end
      ON: begin
        // ack wins over a coincident phase expiry and its beep_count update
        if (bus.ack) begin
          state_n = HOLD;
          buzz_n  = 1'b0;
        end else if (phase_cnt == ON_LAST) begin
          beep_n  = beep_inc;
          buzz_n  = 1'b0;
          phase_n = '0;
          tone_n  = '0;
          state_n = (BURST != 8'd0 && beep_inc == BURST) ? HOLD : OFF;
        end else begin
          phase_n = phase_cnt + 1'b1;
          if (tone_cnt == TONE_LAST) begin
            tone_n = '0;
            buzz_n = ~buzz;
          end else begin
            tone_n = tone_cnt + 1'b1;
          end
        end
      end
      OFF: begin
        buzz_n = 1'b0;
        if (bus.ack) begin
          state_n = HOLD;
        end else if (phase_cnt == OFF_LAST) begin
          state_n = ON;
          phase_n = '0;
          tone_n  = '0;
        end else begin
          phase_n = phase_cnt + 1'b1;
        end
      end
      HOLD: begin
        buzz_n = 1'b0;
        if (!bus.trigger) begin
          state_n = IDLE;
          beep_n  = 8'd0;
        end
      end
      default: begin
        state_n = IDLE;
        buzz_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tone_cnt  <= '0;
      phase_cnt <= '0;
      buzz      <= 1'b0;
      beep_cnt  <= 8'd0;
      active_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_n;
      tone_cnt  <= tone_n;
      phase_cnt <= phase_n;
      buzz      <= buzz_n;
      beep_cnt  <= beep_n;
      active_r  <= (state_n == ON) || (state_n == OFF);
      done_r    <= (state_n == HOLD);
    end
  end

  assign bus.buzzer_out = buzz;
  assign bus.active     = active_r;
  assign bus.done       = done_r;
  assign bus.beep_count = beep_cnt;
endmodule

// File: tb/tb_buzzer_driver.sv
// tb/tb_buzzer_driver.sv - scoreboard bench for buzzer_driver
module tb_buzzer_driver;
  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  buzzer_driver_if bus0 ();
  buzzer_driver_if bus1 ();

  buzzer_driver #(.HALF_PERIOD(2), .ON_CYCLES(8), .OFF_CYCLES(4), .BURST_COUNT(2))
    dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  buzzer_driver #(.HALF_PERIOD(2), .ON_CYCLES(8), .OFF_CYCLES(4), .BURST_COUNT(0))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  // expected word: {buzzer_out, active, done, beep_count[7:0]}
  typedef struct {
    int         c;
    int         d;
    logic [10:0] v;
  } exp_t;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] sample(input int d);
    if (d == 0) return {bus0.buzzer_out, bus0.active, bus0.done, bus0.beep_count};
    return {bus1.buzzer_out, bus1.active, bus1.done, bus1.beep_count};
  endfunction

  initial begin
    checks = 0;
    failures = 0;
  end

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].c <= cyc) begin
        logic [10:0] act;
        act = sample(sb[i].d);
        checks = checks + 1;
        if (sb[i].c < cyc) begin
          failures = failures + 1;
          $display("FAIL stale dut%0d cyc=%0d not sampled (now %0d)", sb[i].d, sb[i].c, cyc);
        end else if (act !== sb[i].v) begin
          failures = failures + 1;
          $display("FAIL dut%0d cyc=%0d got=%03h want=%03h", sb[i].d, sb[i].c, act, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  task automatic chk(input int c, input int d, input logic [10:0] v);
    exp_t e;
    e.c = c;
    e.d = d;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus0.trigger = 1'b0; bus0.ack = 1'b0;
    bus1.trigger = 1'b0; bus1.ack = 1'b0;
    chk(1, 0, 11'h000);
    chk(1, 1, 11'h000);
    goto(2);
    reset = 1'b0;
    chk(5, 0, 11'h000);

    // full two-beep burst, trigger held
    chk(10, 0, 11'h200); chk(11, 0, 11'h200); chk(12, 0, 11'h600);
    chk(14, 0, 11'h200); chk(16, 0, 11'h600); chk(18, 0, 11'h201);
    chk(21, 0, 11'h201); chk(22, 0, 11'h201); chk(24, 0, 11'h601);
    chk(29, 0, 11'h601); chk(30, 0, 11'h102); chk(33, 0, 11'h102);
    goto(9);  bus0.trigger = 1'b1;

    // release, then re-raise and ack on the 3rd ON cycle
    chk(36, 0, 11'h000); chk(40, 0, 11'h200); chk(42, 0, 11'h600);
    chk(43, 0, 11'h100);
    goto(35); bus0.trigger = 1'b0;
    goto(39); bus0.trigger = 1'b1;
    goto(42); bus0.ack = 1'b1;
    goto(43); bus0.ack = 1'b0;

    // ack coincident with ON expiry keeps beep_count at 0
    chk(46, 0, 11'h000); chk(50, 0, 11'h200); chk(57, 0, 11'h600);
    chk(58, 0, 11'h100); chk(60, 0, 11'h100);
    goto(45); bus0.trigger = 1'b0;
    goto(49); bus0.trigger = 1'b1;
    goto(57); bus0.ack = 1'b1;
    goto(58); bus0.ack = 1'b0;

    // ack alone in IDLE ignored; ack with trigger in IDLE goes straight to HOLD
    chk(62, 0, 11'h000); chk(63, 0, 11'h000); chk(65, 0, 11'h100);
    chk(66, 0, 11'h100);
    goto(61); bus0.trigger = 1'b0;
    goto(62); bus0.ack = 1'b1;
    goto(63); bus0.ack = 1'b0;
    goto(64); bus0.trigger = 1'b1; bus0.ack = 1'b1;
    goto(65); bus0.ack = 1'b0;

    // trigger dropped mid-burst: cadence completes, HOLD exits at once
    chk(67, 0, 11'h000); chk(70, 0, 11'h200); chk(80, 0, 11'h201);
    chk(82, 0, 11'h201); chk(90, 0, 11'h102); chk(91, 0, 11'h000);
    goto(66); bus0.trigger = 1'b0;
    goto(69); bus0.trigger = 1'b1;
    goto(71); bus0.trigger = 1'b0;

    // async reset between edges while buzzer_out is high
    chk(97, 0, 11'h000); chk(98, 0, 11'h000); chk(99, 0, 11'h200);
    chk(101, 0, 11'h600);
    goto(94); bus0.trigger = 1'b1;
    goto(96);
    @(posedge clk);
    #2 reset = 1'b1;
    goto(98);
    #2 reset = 1'b0;

    // unlimited burst: beep_count saturates at 255, only ack ends it
    chk(118, 1, 11'h600); chk(119, 1, 11'h201);
    chk(3166, 1, 11'h6FE); chk(3167, 1, 11'h2FF); chk(3178, 1, 11'h6FF);
    chk(3179, 1, 11'h2FF); chk(3181, 1, 11'h2FF); chk(3186, 1, 11'h1FF);
    chk(3189, 1, 11'h000);
    goto(110); bus1.trigger = 1'b1;
    goto(3185); bus1.ack = 1'b1;
    goto(3186); bus1.ack = 1'b0;
    goto(3188); bus1.trigger = 1'b0;

    goto(3195);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
